spr_update_sched: RTL and testbench
===================================

# spr_update_sched

Vblank-synchronised update scheduler for the sprite register bank. It sits between the serial `sprite_control` decoder and the `sprite_reg` instances, and buffers decoded register writes into a FIFO. Writes are released to the registers only after a commit command is received and the VGA timing is in vertical blanking, so sprite position and colour never change mid-frame and no tearing occurs. Each drained batch ends with a single-cycle `applied` pulse that software can use for frame pacing.

## Interface
- `DEPTH`, 16, FIFO entries; must be a power of 2, minimum 2.
- `CMD_W`, 4, command width; matches `sprite_control`.
- `DATA_W`, 10, data width; matches `sprite_control`.
- `COMMIT_CMD`, 4'hF, command code that marks end of batch; never stored.

- `clk`  in  1  system clock, same as the VGA timing logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vblank`  in  1  high while the V counter is outside the draw window; synchronous to `clk`.
- `in_write`  in  1  one-cycle write strobe from the decoder.
- `in_command`  in  CMD_W  decoded command.
- `in_data`  in  DATA_W  decoded data.
- `out_write`  out  1  registered write strobe to `sprite_reg`.
- `out_command`  out  CMD_W  registered command.
- `out_data`  out  DATA_W  registered data.
- `pending`  out  1  high while a commit is waiting for, or being drained in, vblank.
- `applied`  out  1  one-cycle pulse when a committed batch has been fully written.
- `overflow`  out  1  sticky flag: a write was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset (async, `reset_n`=0):**
  - FIFO emptied; committed count C=0; state IDLE.
  - All outputs 0, including `overflow`.
- **Push:**
  - Condition: `in_write`=1 and `in_command`≠COMMIT_CMD.
  - Effect: {cmd,data} is appended to the FIFO.
  - When full: the write is dropped and `overflow` is set.
  - Full with a pop in the same cycle: the push is accepted.
- **Commit:**
  - Condition: `in_write`=1 and `in_command`==COMMIT_CMD.
  - Effect: C is set to the FIFO level after this cycle's pop, excluding any same-cycle push (a push cannot coincide, since there is one strobe per cycle).
  - Every entry present at the commit belongs to the committed batch.
- **States:**
  - IDLE:
    - Commit goes to ARMED.
    - Writes only push.
  - ARMED:
    - `pending`=1.
    - `vblank`=1 with C>0 goes to DRAIN.
    - `vblank`=1 with C=0 (empty commit) pulses `applied` and goes to IDLE.
  - DRAIN:
    - `pending`=1.
    - Each clock pops the head, drives `out_write`=1 with that entry, and decrements C.
    - On the pop that takes C to 0, `applied` is pulsed in the same cycle as the last `out_write`, then the state returns to IDLE.
- **During ARMED/DRAIN:**
  - Non-commit writes push behind the batch and belong to the next batch.
  - A further commit resets C to the current post-pop level, which extends the batch.
  - A commit in the final DRAIN cycle keeps the state in DRAIN if the new C>0.
- **Vblank ends mid-DRAIN:**
  - The drain continues to completion.
  - A batch is at most DEPTH cycles, far shorter than vblank.
- `overflow` clears only on reset.
- `out_command`/`out_data` hold their last value while `out_write`=0.

## Timing
- ARMED samples `vblank`=1 at edge E0.
- First `out_write` is high in the cycle after E1.
- N entries produce `out_write` after edges E1..EN, back-to-back with no gaps.
- `applied` is high after EN, coincident with the last write.
- Empty commit: `applied` is high after E0.
- Commit sampled at edge Ec: `pending` is high after Ec.
- `level` is registered and updates the cycle after a push or pop.
- Minimum commit-to-first-write latency with `vblank` already high is 3 edges: commit, arm sample, drain.

## Configuration
- **`SPR_SCHED_VBLANK_GATE_EN` defined:** ARMED waits for `vblank`=1, as described above.
- **Not defined:**
  - ARMED treats `vblank` as constantly 1, so the drain starts on the edge after the commit.
  - The `vblank` port is kept but ignored.
  - Useful for bring-up without the timing generator.

## Test plan
- Push 3 writes (cmd 1,2,3, data 10,20,30), commit, hold `vblank`=0 for 100 cycles: `out_write` stays 0 and `pending`=1. Raise `vblank`: 3 consecutive writes 1/10, 2/20, 3/30, `applied` coincident with the third, then `pending`=0.
- Commit with the FIFO empty, then raise `vblank`: exactly one `applied` pulse, no `out_write`.
- Push 17 writes with DEPTH=16: `level`=16, `overflow`=1. After commit and vblank, 16 writes are output; the 17th is absent and `overflow` stays 1.
- During DRAIN of a 4-entry batch, push 2 writes then commit: 6 consecutive `out_write`, and a single `applied` on the 6th.
- Assert `reset_n`=0 during the 2nd drain cycle: all outputs go to 0 immediately and `level`=0. After release, a new commit plus vblank produces a single `applied` and no stale writes.
- Build without the macro, push 2 writes, commit, `vblank`=0: both writes appear on the 2nd and 3rd edges after the commit.

Source files
------------

// File: rtl/spr_update_sched_if.sv
// Write bus between the sprite command decoder and the sprite register bank.
// in_* carries decoded writes into the scheduler; out_* carries released writes.
interface spr_update_sched_if #(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 10
);
    logic              in_write;
    logic [CMD_W-1:0]  in_command;
    logic [DATA_W-1:0] in_data;
    logic              out_write;
    logic [CMD_W-1:0]  out_command;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_write,
        output in_command,
        output in_data,
        input  out_write,
        input  out_command,
        input  out_data
    );

    modport slave (
        input  in_write,
        input  in_command,
        input  in_data,
        output out_write,
        output out_command,
        output out_data
    );
endinterface

// File: rtl/spr_update_sched.sv
// Vblank-synchronised sprite register update scheduler: queues decoded writes
// in a FIFO and releases each committed batch back-to-back during vblank.
// Ports: clk, reset_n (async, active low), vblank, bus (slave: in_* writes in,
// out_* registered writes out), pending, applied (1-cycle), overflow (sticky),
// level (FIFO occupancy).
// Build option: SPR_SCHED_VBLANK_GATE_EN defined = drain waits for vblank;
// undefined = vblank ignored, drain starts on the edge after the commit.
module spr_update_sched #(
    parameter int               DEPTH      = 16,
    parameter int               CMD_W      = 4,
    parameter int               DATA_W     = 10,
    parameter logic [CMD_W-1:0] COMMIT_CMD = {CMD_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vblank,
    spr_update_sched_if.slave      bus,
    output logic                   pending,
    output logic                   applied,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CMD_W + DATA_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spr_update_sched: DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   cnt_q;
    logic [LW-1:0]   c_q;
    logic [LW-1:0]   c_d;
    logic [LW-1:0]   post_pop;

    logic            vblank_ok;
    logic            is_commit;
    logic            is_data;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            applied_d;

`ifdef SPR_SCHED_VBLANK_GATE_EN
    assign vblank_ok = vblank;
`else
    // Bring-up build: behave as if permanently in vblank.
    assign vblank_ok = 1'b1;
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    assign is_commit = bus.in_write
                    && (bus.in_command == COMMIT_CMD);
    assign is_data   = bus.in_write
                    && (bus.in_command != COMMIT_CMD);

    assign full = (cnt_q == LW'(DEPTH));
    assign pop  = (state_q == DRAIN);

    // A full FIFO still accepts a write when the head leaves this cycle.
    assign push = is_data && (!full || pop);
    assign drop = is_data && full && !pop;

    // Batch size seen by a commit: everything left after this cycle's pop.
    assign post_pop = cnt_q - LW'(pop);

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        applied_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_commit) begin
                    c_d     = post_pop;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (is_commit) begin
                    c_d = post_pop;
                end
                if (vblank_ok) begin
                    if (c_d != '0) begin
                        state_d = DRAIN;
                    end else begin
                        applied_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            DRAIN: begin
                // A late commit re-sizes the batch to the
                // whole queue, pulling the newer writes in.
                if (is_commit) begin
                    c_d = post_pop;
                end else begin
                    c_d = c_q - LW'(1);
                end
                if (c_d == '0) begin
                    applied_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                c_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            applied <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            applied <= applied_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_q + LW'(push) - LW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_command, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_write   <= 1'b0;
            bus.out_command <= '0;
            bus.out_data    <= '0;
        end else begin
            bus.out_write <= pop;
            if (pop) begin
                {bus.out_command, bus.out_data} <= mem[rd_ptr];
            end
        end
    end

    assign pending = (state_q != IDLE);
    assign level   = cnt_q;

endmodule

// File: tb/tb_spr_update_sched.sv
// Directed bench for spr_update_sched: a per-cycle vector table with
// vblank held high, then hand sequences for gating, overflow and reset.
module tb_spr_update_sched;

    localparam int DEPTH  = 16;
    localparam int CMD_W  = 4;
    localparam int DATA_W = 10;
    localparam int LW     = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vblank;
    logic          pending;
    logic          applied;
    logic          overflow;
    logic [LW-1:0] level;

    spr_update_sched_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

    spr_update_sched #(
        .DEPTH  (DEPTH),
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vblank   (vblank),
        .bus      (bus.slave),
        .pending  (pending),
        .applied  (applied),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  cmd;
        logic [9:0]  dat;
        logic        ow;
        logic [3:0]  oc;
        logic [9:0]  od;
        logic        pend;
        logic        app;
        logic [4:0]  lvl;
    } vec_t;

    vec_t       tv [23];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] ec [$];
    logic [9:0] ed [$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr,
                         input logic [3:0] c,
                         input logic [9:0] d);
        bus.in_write   = wr;
        bus.in_command = c;
        bus.in_data    = d;
    endtask

    function automatic vec_t mk(logic wr, logic [3:0] c, logic [9:0] d,
                                logic ow, logic [3:0] oc, logic [9:0] od,
                                logic p, logic a, logic [4:0] l);
        vec_t v;
        v = {wr, c, d, ow, oc, od, p, a, l};
        return v;
    endfunction

    // Wait (bounded) for the first write, then expect ec/ed back-to-back
    // with applied only on the last one.
    task automatic collect(input string name, input int n,
                           output int waited);
        int k;
        k = 0;
        while (bus.out_write !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        waited = k;
        check({name, "_start"}, 32'(bus.out_write), 32'd1);
        if (bus.out_write === 1'b1) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_w%0d", name, i),
                      32'({bus.out_write, applied,
                           bus.out_command, bus.out_data}),
                      32'({1'b1, (i == n - 1), ec[i], ed[i]}));
                tick();
            end
            check({name, "_end"},
                  32'({bus.out_write, applied, pending}), 32'd0);
        end
    endtask

    initial begin
        int w;
        int ows;
        int apps;
        int pd_low;

        reset_n = 1'b0;
        vblank  = 1'b1;
        drive(1'b0, 4'h0, 10'd0);
        tick();
        tick();
        check("reset_outs",
              32'({bus.out_write, bus.out_command, bus.out_data,
                   pending, applied, overflow, level}), 32'd0);
        reset_n = 1'b1;

        //          wr   cmd   dat    ow   oc    od     p    a    lvl
        tv[0]  = mk(1, 4'h1, 10'd10, 0, 4'h0, 10'd0,  0, 0, 5'd1);
        tv[1]  = mk(1, 4'h2, 10'd20, 0, 4'h0, 10'd0,  0, 0, 5'd2);
        tv[2]  = mk(1, 4'hF, 10'd0,  0, 4'h0, 10'd0,  1, 0, 5'd2);
        tv[3]  = mk(0, 4'h0, 10'd0,  0, 4'h0, 10'd0,  1, 0, 5'd2);
        tv[4]  = mk(0, 4'h0, 10'd0,  1, 4'h1, 10'd10, 1, 0, 5'd1);
        tv[5]  = mk(0, 4'h0, 10'd0,  1, 4'h2, 10'd20, 0, 1, 5'd0);
        tv[6]  = mk(0, 4'h0, 10'd0,  0, 4'h2, 10'd20, 0, 0, 5'd0);
        tv[7]  = mk(1, 4'hF, 10'd0,  0, 4'h2, 10'd20, 1, 0, 5'd0);
        tv[8]  = mk(0, 4'h0, 10'd0,  0, 4'h2, 10'd20, 0, 1, 5'd0);
        tv[9]  = mk(0, 4'h0, 10'd0,  0, 4'h2, 10'd20, 0, 0, 5'd0);
        tv[10] = mk(1, 4'h4, 10'd40, 0, 4'h2, 10'd20, 0, 0, 5'd1);
        tv[11] = mk(1, 4'h5, 10'd50, 0, 4'h2, 10'd20, 0, 0, 5'd2);
        tv[12] = mk(1, 4'h6, 10'd60, 0, 4'h2, 10'd20, 0, 0, 5'd3);
        tv[13] = mk(1, 4'h7, 10'd70, 0, 4'h2, 10'd20, 0, 0, 5'd4);
        tv[14] = mk(1, 4'hF, 10'd0,  0, 4'h2, 10'd20, 1, 0, 5'd4);
        tv[15] = mk(0, 4'h0, 10'd0,  0, 4'h2, 10'd20, 1, 0, 5'd4);
        tv[16] = mk(1, 4'h8, 10'd80, 1, 4'h4, 10'd40, 1, 0, 5'd4);
        tv[17] = mk(1, 4'h9, 10'd90, 1, 4'h5, 10'd50, 1, 0, 5'd4);
        tv[18] = mk(1, 4'hF, 10'd0,  1, 4'h6, 10'd60, 1, 0, 5'd3);
        tv[19] = mk(0, 4'h0, 10'd0,  1, 4'h7, 10'd70, 1, 0, 5'd2);
        tv[20] = mk(0, 4'h0, 10'd0,  1, 4'h8, 10'd80, 1, 0, 5'd1);
        tv[21] = mk(0, 4'h0, 10'd0,  1, 4'h9, 10'd90, 0, 1, 5'd0);
        tv[22] = mk(0, 4'h0, 10'd0,  0, 4'h9, 10'd90, 0, 0, 5'd0);

        for (int i = 0; i < 23; i++) begin
            drive(tv[i].wr, tv[i].cmd, tv[i].dat);
            tick();
            check($sformatf("vec%0d", i),
                  32'({bus.out_write, bus.out_command, bus.out_data,
                       pending, applied, level}),
                  32'({tv[i].ow, tv[i].oc, tv[i].od,
                       tv[i].pend, tv[i].app, tv[i].lvl}));
        end
        drive(1'b0, 4'h0, 10'd0);
        check("table_no_ovf", 32'(overflow), 32'd0);

`ifdef SPR_SCHED_VBLANK_GATE_EN
        // Batch held off while vblank is low.
        vblank = 1'b0;
        drive(1'b1, 4'h1, 10'd10); tick();
        drive(1'b1, 4'h2, 10'd20); tick();
        drive(1'b1, 4'h3, 10'd30); tick();
        drive(1'b1, 4'hF, 10'd0);  tick();
        drive(1'b0, 4'h0, 10'd0);
        ows = 0;
        pd_low = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.out_write) ows++;
            if (!pending) pd_low++;
        end
        check("hold_no_write", 32'(ows), 32'd0);
        check("hold_pending", 32'(pd_low), 32'd0);
        vblank = 1'b1;
        ec = '{4'h1, 4'h2, 4'h3};
        ed = '{10'd10, 10'd20, 10'd30};
        collect("vb_batch", 3, w);
        check("vb_latency", 32'(w), 32'd2);
`else
        // vblank ignored: writes on the 2nd and 3rd edges after commit.
        vblank = 1'b0;
        drive(1'b1, 4'h1, 10'd10); tick();
        drive(1'b1, 4'h2, 10'd20); tick();
        drive(1'b1, 4'hF, 10'd0);  tick();
        drive(1'b0, 4'h0, 10'd0);
        tick();
        check("ng_e1", 32'({bus.out_write, pending}), 32'b01);
        tick();
        check("ng_e2", 32'({bus.out_write, applied,
                            bus.out_command, bus.out_data}),
              32'({1'b1, 1'b0, 4'h1, 10'd10}));
        tick();
        check("ng_e3", 32'({bus.out_write, applied,
                            bus.out_command, bus.out_data}),
              32'({1'b1, 1'b1, 4'h2, 10'd20}));
        tick();
        check("ng_e4", 32'({bus.out_write, pending}), 32'd0);
`endif

        // Empty commit: one applied pulse, no writes.
        vblank = 1'b0;
        drive(1'b1, 4'hF, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0);
        ows = 0;
        apps = 0;
        pd_low = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_write) ows++;
            if (applied) apps++;
            if (!pending) pd_low++;
            tick();
        end
`ifdef SPR_SCHED_VBLANK_GATE_EN
        check("empty_hold_pend", 32'(pd_low), 32'd0);
`endif
        vblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_write) ows++;
            if (applied) apps++;
            tick();
        end
        check("empty_applied", 32'(apps), 32'd1);
        check("empty_no_write", 32'(ows), 32'd0);
        check("empty_idle", 32'(pending), 32'd0);

        // Overflow: 17 pushes into 16 entries.
        ec.delete();
        ed.delete();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 4'(i % 15), 10'(100 + i));
            tick();
            if (i < 16) begin
                ec.push_back(4'(i % 15));
                ed.push_back(10'(100 + i));
            end
        end
        drive(1'b0, 4'h0, 10'd0);
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        drive(1'b1, 4'hF, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0);
        tick();
        // Push while full on the first pop cycle: must be accepted.
        drive(1'b1, 4'h1, 10'd999);
        tick();
        drive(1'b0, 4'h0, 10'd0);
        collect("ovf_batch", 16, w);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("full_pop_push", 32'(level), 32'd1);
        drive(1'b1, 4'hF, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0);
        ec = '{4'h1};
        ed = '{10'd999};
        collect("late_batch", 1, w);

        // Reset in the middle of a drain.
        drive(1'b1, 4'h1, 10'd11); tick();
        drive(1'b1, 4'h2, 10'd12); tick();
        drive(1'b1, 4'h3, 10'd13); tick();
        drive(1'b1, 4'hF, 10'd0);  tick();
        drive(1'b0, 4'h0, 10'd0);
        w = 0;
        while (bus.out_write !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("rst_drain_start", 32'(bus.out_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_outs",
              32'({bus.out_write, bus.out_command, bus.out_data,
                   pending, applied, overflow, level}), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        drive(1'b1, 4'hF, 10'd0);
        tick();
        drive(1'b0, 4'h0, 10'd0);
        ows = 0;
        apps = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_write) ows++;
            if (applied) apps++;
            tick();
        end
        check("rst_applied", 32'(apps), 32'd1);
        check("rst_no_stale", 32'(ows), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
